// File: rtl/bus_test_sequencer_if.sv
// bus_test_sequencer_if
// Groups the per-master bus signals that run between the sequencer and the
// bus masters it drives. Packed per-master fields put master i at
// [i*W +: W] for each field width W.
//
// Signals:
//   m_request    per-master busy/request, driven by the masters
//   m_enable     per-master enable
//   m_read_en    per-master read(1)/write(0)
//   m_burst_mode per-master burst mode, packed
//   m_data       per-master data, packed
//   m_addr       per-master address, packed
//
// Modports:
//   master  sequencer side (drives the master controls, observes requests)
//   slave   bus-master side (drives requests, observes the controls)
interface bus_test_sequencer_if #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 14,
  parameter int BURST_W   = 3
);

  logic [N_MASTERS-1:0]         m_request;
  logic [N_MASTERS-1:0]         m_enable;
  logic [N_MASTERS-1:0]         m_read_en;
  logic [N_MASTERS*BURST_W-1:0] m_burst_mode;
  logic [N_MASTERS*DATA_W-1:0]  m_data;
  logic [N_MASTERS*ADDR_W-1:0]  m_addr;

  modport master (
    input  m_request,
    output m_enable,
    output m_read_en,
    output m_burst_mode,
    output m_data,
    output m_addr
  );

  modport slave (
    output m_request,
    input  m_enable,
    input  m_read_en,
    input  m_burst_mode,
    input  m_data,
    input  m_addr
  );

endinterface

// File: rtl/bus_test_sequencer.sv
// bus_test_sequencer
// Programmable stimulus sequencer. A step table is loaded while idle; a run
// walks the table from start_idx, driving one master per step for
// ENABLE_CYCLES cycles after an optional idle gap, then waits for every
// master to drop its request (bounded by TIMEOUT cycles).
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   start        run request, accepted only while idle
//   start_idx    first step of the run
//   cfg_we       table write strobe, accepted only while idle
//   cfg_idx      table write index
//   cfg_data     table entry {last, gap, master, read, burst, addr, data}
//   bus          per-master bus signals (sequencer-side modport)
//   busy         high while a run is in progress
//   done         one-cycle pulse at the end of a run
//   timeout_err  sticky WAIT timeout flag, cleared by an accepted start
//   step_out     index of the current step
module bus_test_sequencer #(
  parameter int N_MASTERS     = 2,
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 14,
  parameter int BURST_W       = 3,
  parameter int N_STEPS       = 16,
  parameter int GAP_W         = 4,
  parameter int ENABLE_CYCLES = 3,
  parameter int TIMEOUT       = 255,
  localparam int IW      = $clog2(N_STEPS),
  localparam int MW      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int ENTRY_W = 1 + GAP_W + MW + 1 + BURST_W + ADDR_W + DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IW-1:0]       start_idx,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_idx,
  input  logic [ENTRY_W-1:0]  cfg_data,
  bus_test_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [IW-1:0]       step_out
);

  typedef struct packed {
    logic               last;
    logic [GAP_W-1:0]   gap;
    logic [MW-1:0]      master;
    logic               read;
    logic [BURST_W-1:0] burst;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } entry_t;

  // One shared counter times the gap, the issue window and the wait, so it
  // must hold the largest of the three limits.
  localparam int CNT_A   = (TIMEOUT > ENABLE_CYCLES) ? TIMEOUT : ENABLE_CYCLES;
  localparam int CNT_MAX = (CNT_A > (1 << GAP_W)) ? CNT_A : (1 << GAP_W);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RUN_W   = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  entry_t               tbl [N_STEPS];
  entry_t               cur;
  logic [IW-1:0]        step_idx;
  logic [RUN_W-1:0]     steps_run;
  logic [CNT_W-1:0]     cnt;
  logic                 req_any;
  logic                 wait_timeout;

  logic [N_MASTERS-1:0]         enable_d;
  logic [N_MASTERS-1:0]         read_d;
  logic [N_MASTERS*BURST_W-1:0] burst_d;
  logic [N_MASTERS*DATA_W-1:0]  data_d;
  logic [N_MASTERS*ADDR_W-1:0]  addr_d;
  logic                         busy_d;
  logic                         done_d;

  assign req_any      = |bus.m_request;
  assign wait_timeout = (state == S_WAIT) && req_any &&
                        (cnt == CNT_W'(TIMEOUT - 1));
  assign step_out     = step_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      // The entry is still being registered, so the gap test reads the table.
      S_LOAD:  state_next = (tbl[step_idx].gap != '0) ? S_GAP : S_ISSUE;
      S_GAP:   if (cnt == CNT_W'(cur.gap - 1'b1)) state_next = S_ISSUE;
      S_ISSUE: if (cnt == CNT_W'(ENABLE_CYCLES - 1)) state_next = S_WAIT;
      S_WAIT: begin
        if (!req_any) begin
          state_next = (cur.last || (steps_run == RUN_W'(N_STEPS))) ? S_DONE : S_LOAD;
        end else if (wait_timeout) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A master field that matches no master index leaves every master silent.
  always_comb begin
    enable_d = '0;
    read_d   = '0;
    burst_d  = '0;
    data_d   = '0;
    addr_d   = '0;
    busy_d   = (state != S_IDLE);
    done_d   = (state == S_DONE);
    if ((state == S_ISSUE) || (state == S_WAIT)) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (cur.master == MW'(i)) begin
          enable_d[i]                   = (state == S_ISSUE);
          read_d[i]                     = cur.read;
          burst_d[i*BURST_W +: BURST_W] = cur.burst;
          data_d[i*DATA_W +: DATA_W]    = cur.data;
          addr_d[i*ADDR_W +: ADDR_W]    = cur.addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.m_enable     <= '0;
      bus.m_read_en    <= '0;
      bus.m_burst_mode <= '0;
      bus.m_data       <= '0;
      bus.m_addr       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      bus.m_enable     <= enable_d;
      bus.m_read_en    <= read_d;
      bus.m_burst_mode <= burst_d;
      bus.m_data       <= data_d;
      bus.m_addr       <= addr_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

  // The counter restarts on every state change so each phase times itself
  // from zero; it is parked at zero while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_STEPS; i++) begin
        tbl[i] <= '0;
      end
      cur         <= '0;
      step_idx    <= '0;
      steps_run   <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == S_IDLE) && cfg_we) begin
        tbl[cfg_idx] <= cfg_data;
      end
      if ((state == S_IDLE) || (state_next != state)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            step_idx    <= start_idx;
            steps_run   <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_LOAD: begin
          cur       <= tbl[step_idx];
          steps_run <= steps_run + 1'b1;
        end
        S_WAIT: begin
          if (state_next == S_LOAD) begin
            step_idx <= step_idx + 1'b1;
          end else if (wait_timeout) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_test_sequencer.sv
// tb_bus_test_sequencer
// Self-checking bench for bus_test_sequencer. For each run a reference
// model turns the step table, the start index and a per-step request hold
// length into a cycle-by-cycle timeline of expected outputs and of the
// m_request values to drive. The bench plays the timeline and compares the
// full output vector every cycle. Random start/cfg_we noise is injected
// while the sequencer is busy; it must have no effect.
module tb_bus_test_sequencer;

  localparam int N_MASTERS     = 2;
  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 14;
  localparam int BURST_W       = 3;
  localparam int N_STEPS       = 16;
  localparam int GAP_W         = 4;
  localparam int ENABLE_CYCLES = 3;
  localparam int TIMEOUT       = 255;
  localparam int IW            = 4;
  localparam int ENTRY_W       = 32;
  localparam int MAXF          = 2048;

  logic               clk;
  logic               reset;
  logic               start;
  logic [IW-1:0]      start_idx;
  logic               cfg_we;
  logic [IW-1:0]      cfg_idx;
  logic [ENTRY_W-1:0] cfg_data;
  logic               busy;
  logic               done;
  logic               timeout_err;
  logic [IW-1:0]      step_out;

  bus_test_sequencer_if #(
    .N_MASTERS(N_MASTERS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)
  ) bus ();

  bus_test_sequencer #(
    .N_MASTERS(N_MASTERS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
    .N_STEPS(N_STEPS), .GAP_W(GAP_W), .ENABLE_CYCLES(ENABLE_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_idx(start_idx),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_data(cfg_data),
    .bus(bus),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .step_out(step_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] dut_vec;
  assign dut_vec = {3'b000, busy, done, timeout_err, step_out, bus.m_enable, bus.m_read_en,
                    bus.m_burst_mode, bus.m_addr, bus.m_data};

  int check_count = 0;
  int pass_count  = 0;
  int run_no      = 0;

  // Reference table and per-run expected timeline.
  logic [31:0] tbl [N_STEPS];
  bit          f_busy  [MAXF];
  bit          f_done  [MAXF];
  bit          f_terr  [MAXF];
  logic [3:0]  f_step  [MAXF];
  int          f_drive [MAXF];
  logic [31:0] f_entry [MAXF];
  logic [1:0]  f_req   [MAXF];
  int          n_frames;
  int          last_busy;
  int          hold_plan [$];
  logic [1:0]  req_hi;
  bit          noise;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_entry(input bit last, input int gap, input int master,
                                           input bit read, input int burst, input int addr,
                                           input int data);
    return {last, 4'(gap), 1'(master), read, 3'(burst), 14'(addr), 8'(data)};
  endfunction

  function automatic logic [63:0] pack_frame(input int c);
    logic [1:0]  en;
    logic [1:0]  rd;
    logic [5:0]  bu;
    logic [27:0] ad;
    logic [15:0] da;
    logic [31:0] e;
    int          m;
    en = '0; rd = '0; bu = '0; ad = '0; da = '0;
    e  = f_entry[c];
    if (f_drive[c] != 0) begin
      m              = int'(e[26]);
      en[m]          = (f_drive[c] == 1);
      rd[m]          = e[25];
      bu[m*3 +: 3]   = e[24:22];
      ad[m*14 +: 14] = e[21:8];
      da[m*8 +: 8]   = e[7:0];
    end
    return {3'b000, f_busy[c], f_done[c], f_terr[c], f_step[c], en, rd, bu, ad, da};
  endfunction

  // Frame c is the output state seen just after the c-th rising edge
  // following the edge that accepts start; f_req[c] is driven in that frame.
  task automatic build_run(input int sidx);
    int          idx;
    int          run;
    int          b;
    int          w;
    int          x;
    int          h;
    bit          fin;
    bit          tmo;
    logic [31:0] e;
    for (int c = 0; c < MAXF; c++) begin
      f_busy[c] = 0; f_done[c] = 0; f_terr[c] = 0; f_step[c] = '0;
      f_drive[c] = 0; f_entry[c] = '0; f_req[c] = 2'($urandom);
    end
    idx = sidx; run = 0; b = 0; fin = 0; tmo = 0; x = 0;
    while (!fin) begin
      e = tbl[idx];
      run++;
      for (int c = b; c < MAXF; c++) f_step[c] = 4'(idx);
      w = b + 1 + int'(e[30:27]) + ENABLE_CYCLES;
      for (int c = w - ENABLE_CYCLES + 1; c <= w; c++) begin
        f_drive[c] = 1; f_entry[c] = e;
      end
      h = (hold_plan.size() > 0) ? hold_plan.pop_front() : int'($urandom_range(0, 4));
      for (int c = w; (c < w + h) && (c < w + TIMEOUT); c++) begin
        f_req[c] = (req_hi != 2'b00) ? req_hi : 2'($urandom_range(1, 3));
      end
      if (h >= TIMEOUT) begin
        x = w + TIMEOUT; tmo = 1; fin = 1;
      end else begin
        f_req[w + h] = 2'b00;
        x = w + h + 1;
        if (e[31] || (run == N_STEPS)) fin = 1;
      end
      for (int c = w + 1; c <= x; c++) begin
        f_drive[c] = 2; f_entry[c] = e;
      end
      if (!fin) begin
        idx = (idx + 1) % N_STEPS;
        b = x;
      end
    end
    for (int c = 1; c <= x + 1; c++) f_busy[c] = 1;
    f_done[x + 1] = 1;
    if (tmo) for (int c = x; c < MAXF; c++) f_terr[c] = 1;
    n_frames  = x + 4;
    last_busy = x;
  endtask

  task automatic writeEntry(input int idx, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[idx] = data;
  endtask

  task automatic applyStimulus(input int sidx, input bit wr_at_start, input logic [31:0] wr_data);
    if (wr_at_start) tbl[sidx] = wr_data;
    build_run(sidx);
    @(negedge clk);
    start = 1'b1; start_idx = 4'(sidx); bus.m_request = '0;
    cfg_we = wr_at_start; cfg_idx = 4'(sidx); cfg_data = wr_data;
    for (int c = 0; c < n_frames; c++) begin
      @(negedge clk);
      checkOutput($sformatf("run%0d_frame%0d", run_no, c), dut_vec, pack_frame(c));
      bus.m_request = f_req[c];
      if (noise && (c <= last_busy)) begin
        start = 1'($urandom); start_idx = 4'($urandom);
        cfg_we = 1'($urandom); cfg_idx = 4'($urandom); cfg_data = $urandom;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
    end
    bus.m_request = '0; start = 1'b0; cfg_we = 1'b0;
    run_no++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start_idx = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    bus.m_request = '0; req_hi = 2'b00; noise = 0;
    for (int i = 0; i < N_STEPS; i++) tbl[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", dut_vec, 64'd0);
    reset = 1'b1;

    $display("[TB] single step, master 0 write");
    writeEntry(0, mk_entry(1, 0, 0, 0, 0, 'h1555, 'hAA));
    hold_plan = '{0};
    applyStimulus(0, 0, '0);

    $display("[TB] three-step chain with gap and held request");
    writeEntry(2, mk_entry(0, 0, 1, 1, 3, 'h0F0F, 'h3C));
    writeEntry(3, mk_entry(0, 2, 0, 0, 1, 'h2222, 'h81));
    writeEntry(4, mk_entry(1, 0, 1, 1, 6, 'h3ABC, 'hE7));
    req_hi = 2'b10;
    hold_plan = '{5, 0, 0};
    applyStimulus(2, 0, '0);

    $display("[TB] wait timeout");
    writeEntry(5, mk_entry(0, 1, 0, 0, 2, 'h0123, 'h55));
    writeEntry(6, mk_entry(1, 0, 1, 1, 7, 'h3FFF, 'hFF));
    req_hi = 2'b01;
    hold_plan = '{TIMEOUT + 10};
    applyStimulus(5, 0, '0);
    req_hi = 2'b00;

    $display("[TB] wrap-around runaway");
    for (int i = 0; i < N_STEPS; i++) begin
      writeEntry(i, mk_entry(0, $urandom_range(0, 3), $urandom_range(0, 1), 1'($urandom),
                             $urandom, $urandom, $urandom));
    end
    noise = 1;
    applyStimulus(14, 0, '0);

    $display("[TB] random tables and runs");
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N_STEPS; i++) begin
        writeEntry(i, mk_entry($urandom_range(0, 3) == 0, $urandom_range(0, 15),
                               $urandom_range(0, 1), 1'($urandom), $urandom, $urandom, $urandom));
      end
      applyStimulus($urandom_range(0, N_STEPS - 1), 1'($urandom),
                    mk_entry(1'($urandom), $urandom_range(0, 5), $urandom_range(0, 1),
                             1'($urandom), $urandom, $urandom, $urandom));
    end

    $display("[TB] async reset during issue");
    noise = 0;
    writeEntry(0, mk_entry(0, 0, 1, 1, 5, 'h02AB, 'h5C));
    @(negedge clk);
    start = 1'b1; start_idx = '0; bus.m_request = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_enable", {62'd0, bus.m_enable}, 64'd2);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset_outputs", dut_vec, 64'd0);
    #1 reset = 1'b1;
    for (int i = 0; i < N_STEPS; i++) tbl[i] = '0;
    noise = 1;
    applyStimulus(0, 0, '0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/bus_test_sequencer.md
# bus_test_sequencer

Programmable stimulus sequencer for the ADS bus testbench. It drives N bus masters from a runtime-loaded step table, replacing fixed hardcoded scenarios. Each step selects one master and drives its enable, read, burst, address and data for a fixed number of cycles, then waits for all masters to drop their requests. A bounded timeout ends the wait. The block sits between the test harness and the master ports.

## Interface
- N_MASTERS, 2: number of masters driven (≥2)
- DATA_W, 8: per-master data width
- ADDR_W, 14: per-master address width
- BURST_W, 3: per-master burst-mode width
- N_STEPS, 16: step-table depth (power of two); IW = clog2(N_STEPS)
- GAP_W, 4: width of per-step idle-gap field
- ENABLE_CYCLES, 3: cycles m_enable is held per step (≥1)
- TIMEOUT, 255: max WAIT cycles before abort (≥1)
- Entry layout, MSB→LSB: ENTRY_W = 1+GAP_W+MW+1+BURST_W+ADDR_W+DATA_W, with MW = max(1, clog2(N_MASTERS)). Fields are {last, gap, master, read, burst, addr, data}.

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE only
- start_idx  in  IW  first step to execute
- cfg_we  in  1  table write strobe
- cfg_idx  in  IW  table write index
- cfg_data  in  ENTRY_W  table write data
- m_request  in  N_MASTERS  per-master busy/request from masters
- m_enable  out  N_MASTERS  per-master enable
- m_read_en  out  N_MASTERS  per-master read(1)/write(0)
- m_burst_mode  out  N_MASTERS*BURST_W  packed; master i at [i*BURST_W +: BURST_W]
- m_data  out  N_MASTERS*DATA_W  packed, same scheme
- m_addr  out  N_MASTERS*ADDR_W  packed, same scheme
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sequence end
- timeout_err  out  1  sticky; set on WAIT timeout, cleared on accepted start
- step_out  out  IW  index of the current step

## Operation
- Reset (reset=0): state IDLE; every output 0; table entries all 0; counters 0. Reset takes effect immediately, including mid-sequence.
- Table write: on a clock edge with cfg_we=1 and state IDLE, table[cfg_idx] <= cfg_data. cfg_we is ignored when busy.
- States:
  - IDLE: if start=1, latch step_idx=start_idx, clear timeout_err, clear steps_run, go to LOAD.
  - LOAD: register table[step_idx] into the current-step register and increment steps_run. Go to GAP if gap≠0, else to ISSUE.
  - GAP: count gap cycles with all master outputs at 0, then go to ISSUE.
  - ISSUE: hold for exactly ENABLE_CYCLES cycles, then go to WAIT.
  - WAIT: exit when m_request is all zeros. If the step's last=1 or steps_run==N_STEPS, go to DONE; otherwise step_idx <= step_idx+1 (wraps modulo N_STEPS) and go to LOAD. If TIMEOUT cycles elapse with any request high, set timeout_err and go to DONE (abort).
  - DONE: pulse done for 1 cycle, then go to IDLE.
- Output drive (registered):
  - In ISSUE, the selected master gets enable=1 plus read, burst, addr, data from the entry.
  - In WAIT, the selected master gets enable=0 while read, burst, addr and data hold their values.
  - Non-selected masters are all-zero in every state. In IDLE, LOAD, GAP and DONE every master is all-zero.
- Master field ≥ N_MASTERS: step executes with no master driven (silent step). WAIT still applies.
- Simultaneous cfg_we and start in IDLE: the write lands, and the following LOAD sees the new contents.
- start while busy: ignored.

## Timing
- Let start be sampled high at edge E0.
  - LOAD occupies the cycle after E0.
  - The first m_enable rise is at edge E0+2+gap.
  - m_enable stays high for ENABLE_CYCLES edges, then falls.
- The WAIT exit check uses m_request sampled at each edge in WAIT, with the first check on the edge after the last ISSUE cycle. Minimum WAIT is 1 cycle.
- Per-step overhead is 1 (LOAD) + gap + ENABLE_CYCLES + WAIT cycles.
- The timeout fires on the TIMEOUT-th WAIT cycle with a request still high. The wait counter resets on each WAIT entry.
- done rises 1 edge after the WAIT exit. busy falls 1 edge after done.
- step_out updates on the edge that enters LOAD.

## Test plan
- Load step0 = {last=1, gap=0, master=0, write, burst=0, addr=0x1555, data=0xAA}; start with start_idx=0, m_request low -> m_enable[0] high for edges E0+2..E0+4, m_data[7:0]=0xAA, m_addr[13:0]=0x1555, done at E0+6, m_enable[1] never high.
- Three-step chain: steps 2,3,4 alternating master1 read / master0 write, gap=2 on step 3, last on 4; m_request[1] held high 5 cycles after step 2 -> step_out goes 2,3,4; step 3's enable is delayed by 2 idle cycles; step 3 is not issued until m_request clears.
- Timeout: TIMEOUT=255, m_request[0] stuck high -> timeout_err=1 after 255 WAIT cycles, done pulses, later steps are skipped; the next start clears timeout_err.
- Wrap/runaway: start_idx=14, no last flags -> steps 14,15,0,1,...,13 execute (16 total), then done.
- Async reset asserted mid-ISSUE -> all outputs 0 with no clock edge; table cleared. Asserting cfg_we while busy -> table unchanged, confirmed by reading back via a rerun.
